// File: rtl/seq_divider_pkg.sv
// Shared types and default sizes for the iterative restoring divider.
package seq_divider_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;
    localparam int CNT_W          = $clog2(DEF_DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor and keep the difference only when it does not borrow.
module seq_divider_div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   pr,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;
    logic               borrow;

    assign shifted         = {pr[DIVISOR_W-1:0], dividend_bit};
    assign {borrow, diff}  = {1'b0, shifted} - {2'b00, divisor};

    // pr[DIVISOR_W] is always 0 since pr < divisor; OR-ing it in keeps the
    // step arithmetically correct for any pr without changing the result.
    assign q_bit   = pr[DIVISOR_W] | ~borrow;
    assign pr_next = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider: one quotient bit per clock, MSB first, with
// output registers that only change on the edge entering DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_W + 1);

    state_t                state_reg, state_next;
    logic [CW-1:0]         count_reg;
    logic [DIVISOR_W:0]    pr_reg;
    logic [DIVIDEND_W-1:0] dq_reg;
    logic [DIVISOR_W-1:0]  dsr_reg;
    logic [DIVIDEND_W-1:0] quotient_reg;
    logic [DIVISOR_W-1:0]  remainder_reg;
    logic                  dbz_reg;

    logic [DIVISOR_W:0]    pr_next;
    logic                  q_bit;
    logic                  last_step;

    // dq_reg shifts dividend bits out of the MSB while quotient bits enter
    // at the LSB, so after the final step it holds the full quotient.
    seq_divider_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .pr           (pr_reg),
        .dividend_bit (dq_reg[DIVIDEND_W-1]),
        .divisor      (dsr_reg),
        .pr_next      (pr_next),
        .q_bit        (q_bit)
    );

    assign last_step = (count_reg == CW'(DIVIDEND_W - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            pr_reg        <= '0;
            dq_reg        <= '0;
            dsr_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        dsr_reg   <= divisor;
                        dq_reg    <= dividend;
                        count_reg <= '0;
                        pr_reg    <= '0;
                        dbz_reg   <= 1'b0;
                        if (divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend[DIVISOR_W-1:0];
                            dbz_reg       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    pr_reg    <= pr_next;
                    dq_reg    <= {dq_reg[DIVIDEND_W-2:0], q_bit};
                    count_reg <= count_reg + 1'b1;
                    if (last_step) begin
                        quotient_reg  <= {dq_reg[DIVIDEND_W-2:0], q_bit};
                        remainder_reg <= pr_next[DIVISOR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule
